four_to_two_encoder: RTL and testbench
======================================

Name: four_to_two_encoder

Overview:
- 4-input to 2-bit priority encoder with registered outputs.
- Converts four single-bit request lines (A, B, C, D) into a 2-bit binary index {E1, E0}, plus a valid flag and a multi-hot flag.
- Intended as a small leaf block feeding select/index logic in lab-level datapaths.
- One clock domain; asynchronous active-high reset.

Parameters:
- REGISTERED, 1, 1 = outputs registered (one-cycle latency); 0 = outputs purely combinational from A..D, and reset has no effect.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- A  input  1  request line, index 0 (lowest priority)
- B  input  1  request line, index 1
- C  input  1  request line, index 2
- D  input  1  request line, index 3 (highest priority)
- E0  output  1  encoded index, LSB
- E1  output  1  encoded index, MSB
- V  output  1  valid: at least one request line high
- M  output  1  multi-hot: two or more request lines high

Behaviour:
- Clocking and reset:
  - One clock, clk; reset rst is asynchronous and active-high.
  - While rst=1: E0=0, E1=0, V=0, M=0 immediately, with no clock edge needed.
  - On rst deassertion, outputs hold 0 until the next rising clk edge.
- Encoding is priority based, with D > C > B > A:
  - D=1 -> {E1,E0}=11
  - else C=1 -> 10
  - else B=1 -> 01
  - else A=1 -> 00
  - none high -> 00 with V=0
- For one-hot inputs, the priority encoding matches the plain OR encoder (E0=B|D, E1=C|D). Multi-hot inputs resolve by priority, not by OR; for example, B=C=1 gives 10, not 11.
- V = A|B|C|D.
- M = 1 when popcount(A,B,C,D) >= 2.
- Latency when REGISTERED=1:
  - E0, E1, V and M update on each rising clk edge from the A..D values sampled at that edge; latency is exactly 1 cycle.
  - Inputs are sampled every cycle; there is no handshake or enable.
- Input changes between clock edges have no effect on the outputs until the next edge, so glitches are filtered out.
- Reset asserted mid-stream clears all outputs asynchronously. The first valid output after release reflects the inputs sampled at the first rising edge with rst=0.
- When REGISTERED=0, outputs follow the inputs combinationally with zero latency, and clk/rst are ignored.
- All four inputs low: E=00 and V=0. This is the only way to distinguish "no request" from "A only" (E=00, V=1).
- X/Z on an input is not required to be handled; the bench drives only known values.

Test Plan:
- Reset: assert rst=1 with A=B=C=D=1, no clock edge -> E1E0=00, V=0, M=0 immediately. Release rst; after one edge -> E1E0=11, V=1, M=1.
- One-hot sweep: drive A, B, C, D alone, one per cycle -> after 1 cycle each, E1E0 = 00, 01, 10, 11 respectively, V=1, M=0.
- Zero input: A=B=C=D=0 -> E1E0=00, V=0, M=0.
- Priority: B=C=1 -> E1E0=10, M=1. A=B=1 -> 01, M=1. A=D=1 -> 11, M=1.
- Exhaustive binary count: toggle A every 50 ns, B every 100 ns, C every 200 ns and D every 400 ns for 1000 ns, with clk at a 10 ns period. All 16 combinations are covered; each output matches the priority model of the previous-edge inputs, e.g. input 0110 (C,B) -> 10.
- Async reset mid-run: assert rst between edges while D=1 is being output -> outputs drop to 0 before the next edge and stay 0 until one edge after release.

Source files
------------

// File: rtl/four_to_two_encoder.sv
// Purpose : 4-input priority encoder (D > C > B > A) producing a 2-bit index,
//           a valid flag and a multi-hot flag, optionally registered.
// Ports   : clk        - system clock, rising-edge active
//           rst        - asynchronous active-high reset (registered build only)
//           A, B, C, D - request lines, index 0 (lowest) .. 3 (highest)
//           E0, E1     - encoded index {E1,E0} of highest-priority request
//           V          - at least one request line high
//           M          - two or more request lines high
// Params  : REGISTERED - 1: outputs registered, one-cycle latency
//                        0: outputs combinational, clk/rst ignored
module four_to_two_encoder #(
    parameter bit REGISTERED = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic A,
    input  logic B,
    input  logic C,
    input  logic D,
    output logic E0,
    output logic E1,
    output logic V,
    output logic M
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 3;

    logic [IDX_W-1:0] idx_c;
    logic             valid_c;
    logic             multi_c;
    logic [CNT_W-1:0] count_c;

    // Priority encode; multi-hot inputs resolve to the highest index, not an OR.
    always_comb begin
        idx_c = 2'b00;
        if (D) begin
            idx_c = 2'b11;
        end else if (C) begin
            idx_c = 2'b10;
        end else if (B) begin
            idx_c = 2'b01;
        end
    end

    // Valid and multi-hot flags from the raw request lines.
    always_comb begin
        count_c = CNT_W'(A) + CNT_W'(B) + CNT_W'(C) + CNT_W'(D);
        valid_c = A | B | C | D;
        multi_c = (count_c >= CNT_W'(2));
    end

    generate
        if (REGISTERED) begin : g_reg
            // One-cycle registered outputs; reset clears them without a clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    E0 <= 1'b0;
                    E1 <= 1'b0;
                    V  <= 1'b0;
                    M  <= 1'b0;
                end else begin
                    E0 <= idx_c[0];
                    E1 <= idx_c[1];
                    V  <= valid_c;
                    M  <= multi_c;
                end
            end
        end else begin : g_comb
            // Zero-latency pass-through; clk and rst have no effect here.
            assign E0 = idx_c[0];
            assign E1 = idx_c[1];
            assign V  = valid_c;
            assign M  = multi_c;
        end
    endgenerate

endmodule

// File: tb/tb_four_to_two_encoder.sv
// Purpose : Self-checking bench for four_to_two_encoder (REGISTERED=1).
//           Table of hand-computed vectors plus reset/glitch/counting sequences.
module tb_four_to_two_encoder;

    logic clk;
    logic rst;
    logic A, B, C, D;
    logic E0, E1, V, M;

    int n_cmp;
    int n_bad;

    four_to_two_encoder #(.REGISTERED(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .A  (A),
        .B  (B),
        .C  (C),
        .D  (D),
        .E0 (E0),
        .E1 (E1),
        .V  (V),
        .M  (M)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs packed as {D,C,B,A}; expectation packed as {E1,E0,V,M}.
    typedef struct {
        logic [3:0] din;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl [16];

    task automatic drive(input logic [3:0] v);
        {D, C, B, A} = v;
    endtask

    task automatic check(input string name, input logic [3:0] req);
        logic [3:0] act;
        act = {E1, E0, V, M};
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got E1E0VM=%b want %b (time %0t)", name, act, req, $time);
        end
    endtask

    task automatic edge_sample;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Indexed by {D,C,B,A}; expected {E1,E0,V,M} worked by hand.
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b0001, 4'b0010};
        tbl[2]  = '{4'b0010, 4'b0110};
        tbl[3]  = '{4'b0011, 4'b0111};
        tbl[4]  = '{4'b0100, 4'b1010};
        tbl[5]  = '{4'b0101, 4'b1011};
        tbl[6]  = '{4'b0110, 4'b1011};
        tbl[7]  = '{4'b0111, 4'b1011};
        tbl[8]  = '{4'b1000, 4'b1110};
        tbl[9]  = '{4'b1001, 4'b1111};
        tbl[10] = '{4'b1010, 4'b1111};
        tbl[11] = '{4'b1011, 4'b1111};
        tbl[12] = '{4'b1100, 4'b1111};
        tbl[13] = '{4'b1101, 4'b1111};
        tbl[14] = '{4'b1110, 4'b1111};
        tbl[15] = '{4'b1111, 4'b1111};

        // Reset with all requests high: outputs clear before any clock edge.
        rst = 1'b1;
        drive(4'b1111);
        #2;
        check("reset_no_edge", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_release_hold", 4'b0000);
        edge_sample();
        check("reset_first_edge", 4'b1111);

        // One-hot sweep A, B, C, D, then zero input.
        @(negedge clk); drive(4'b0001); edge_sample(); check("onehot_A", 4'b0010);
        @(negedge clk); drive(4'b0010); edge_sample(); check("onehot_B", 4'b0110);
        @(negedge clk); drive(4'b0100); edge_sample(); check("onehot_C", 4'b1010);
        @(negedge clk); drive(4'b1000); edge_sample(); check("onehot_D", 4'b1110);
        @(negedge clk); drive(4'b0000); edge_sample(); check("zero", 4'b0000);

        // Priority cases.
        @(negedge clk); drive(4'b0110); edge_sample(); check("prio_BC", 4'b1011);
        @(negedge clk); drive(4'b0011); edge_sample(); check("prio_AB", 4'b0111);
        @(negedge clk); drive(4'b1001); edge_sample(); check("prio_AD", 4'b1111);

        // Full table, one vector per cycle.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(tbl[i].din);
            edge_sample();
            check($sformatf("table_%0d", i), tbl[i].exp);
        end

        // Mid-cycle input change must not reach the outputs before the edge.
        @(negedge clk); drive(4'b0001); edge_sample();
        drive(4'b1000);
        #2;
        check("glitch_hold", 4'b0010);
        drive(4'b0001);
        edge_sample();
        check("glitch_filtered", 4'b0010);

        // Binary count: A toggles every 50 ns, B 100, C 200, D 400, for 1000 ns.
        // Inputs change on falling edges; each check uses the value at the prior rising edge.
        @(negedge clk);
        for (int cyc = 0; cyc < 100; cyc++) begin
            logic [3:0] cnt;
            cnt = 4'((cyc / 5) % 16);
            drive(cnt);
            edge_sample();
            check($sformatf("count_%0d", cnt), tbl[cnt].exp);
            @(negedge clk);
        end

        // Async reset mid-run while D is being output.
        drive(4'b1000);
        edge_sample();
        check("midrun_before", 4'b1110);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_async_clear", 4'b0000);
        edge_sample();
        check("midrun_held", 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrun_release_hold", 4'b0000);
        edge_sample();
        check("midrun_first_edge", 4'b1110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
